hc595_shift_out: RTL and testbench

//  Serialises one byte into an external 74HC595 shift register through DS, SH_CP and ST_CP.

---
 rtl/hc595_shift_out.sv | 159 +++++++++++++++
 tb/tb_hc595_shift_out.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hc595_shift_out.sv
// Serialises one byte into an external 74HC595 via DS / SH_CP / ST_CP.
// Optional HC595_PENDING_EN adds a 1-deep pending byte chained into the next transfer.
module hc595_shift_out #(
    parameter int CLK_FREQ   = 18_000_000,
    parameter int SHIFT_FREQ = 1_000_000,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_i,
    input  logic       wr_en,
    output logic       busy,
    output logic       ds_o,
    output logic       shcp_o,
    output logic       stcp_o
);
    localparam int DIV_RAW = CLK_FREQ / (2 * SHIFT_FREQ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, SH_LO, SH_HI, LT_HI, LT_LO} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          ds_q, ds_d;
    logic          shcp_q, shcp_d;
    logic          stcp_q, stcp_d;
    logic          half_done;
    logic          start;
    logic [7:0]    start_byte;

    function automatic logic first_bit(input logic [7:0] b);
        return MSB_FIRST ? b[7] : b[0];
    endfunction

`ifdef HC595_PENDING_EN
    logic [7:0] pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       load_pend;

    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        // A write arriving while the slot drains still wins the slot (last byte wins).
        if (wr_en && busy_q) begin
            pend_d     = data_i;
            pend_vld_d = 1'b1;
        end else if (load_pend) begin
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign load_pend  = pend_vld_q && ((state_q == IDLE && !wr_en) ||
                                       (state_q == LT_LO && half_done));
    assign start      = (state_q == IDLE && (wr_en || pend_vld_q)) ||
                        (state_q == LT_LO && half_done && pend_vld_q);
    assign start_byte = (state_q == IDLE && wr_en) ? data_i : pend_q;
`else
    assign start      = (state_q == IDLE) && wr_en;
    assign start_byte = data_i;
`endif

    assign half_done = (div_q == '0);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        ds_d    = ds_q;
        shcp_d  = shcp_q;
        stcp_d  = stcp_q;

        if (state_q != IDLE)
            div_d = half_done ? DIV_M1 : div_q - CW'(1);

        case (state_q)
            SH_LO: if (half_done) begin
                shcp_d  = 1'b1;
                state_d = SH_HI;
            end
            SH_HI: if (half_done) begin
                shcp_d = 1'b0;
                if (bit_q == 3'd7) begin
                    stcp_d  = 1'b1;
                    ds_d    = 1'b0;
                    state_d = LT_HI;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                    ds_d    = MSB_FIRST ? shift_q[6] : shift_q[1];
                    state_d = SH_LO;
                end
            end
            LT_HI: if (half_done) begin
                stcp_d  = 1'b0;
                state_d = LT_LO;
            end
            LT_LO: if (half_done) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: ;
        endcase

        // Loading overrides the LT_LO exit so chained transfers keep busy high.
        if (start) begin
            shift_d = start_byte;
            bit_d   = 3'd0;
            ds_d    = first_bit(start_byte);
            shcp_d  = 1'b0;
            busy_d  = 1'b1;
            div_d   = DIV_M1;
            state_d = SH_LO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
        end
    end

    assign busy   = busy_q;
    assign ds_o   = ds_q;
    assign shcp_o = shcp_q;
    assign stcp_o = stcp_q;
endmodule

// File: tb/tb_hc595_shift_out.sv
// Directed bench: three instances (default, LSB-first, clamped divider) observed by a '595 model.
module tb_hc595_shift_out;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data_s [3];
    logic [2:0] wr_s = '0;
    logic [2:0] busy_w, ds_w, shcp_w, stcp_w;
    logic [2:0] mon_clr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Monitor / behavioural '595 state per instance
    int         rises [3];
    int         latches [3];
    int         busy_cyc [3];
    int         st_w [3];
    int         last_w [3];
    int         viol [3];
    logic [7:0] sr [3]     = '{default: 8'h00};
    logic [7:0] q [3]      = '{default: 8'h00};
    logic [7:0] q_prev [3] = '{default: 8'h00};
    logic [2:0] p_shcp = '0, p_stcp = '0, p_ds = '0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_q;
        int         exp_busy;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    hc595_shift_out dut0 (
        .clk(clk), .rst_n(rst_n), .data_i(data_s[0]), .wr_en(wr_s[0]),
        .busy(busy_w[0]), .ds_o(ds_w[0]), .shcp_o(shcp_w[0]), .stcp_o(stcp_w[0]));
    hc595_shift_out #(.MSB_FIRST(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_i(data_s[1]), .wr_en(wr_s[1]),
        .busy(busy_w[1]), .ds_o(ds_w[1]), .shcp_o(shcp_w[1]), .stcp_o(stcp_w[1]));
    hc595_shift_out #(.SHIFT_FREQ(20_000_000)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_i(data_s[2]), .wr_en(wr_s[2]),
        .busy(busy_w[2]), .ds_o(ds_w[2]), .shcp_o(shcp_w[2]), .stcp_o(stcp_w[2]));

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_clr[i]) begin
                rises[i] = 0; latches[i] = 0; busy_cyc[i] = 0;
                st_w[i] = 0; last_w[i] = 0; viol[i] = 0;
            end else begin
                if (busy_w[i]) busy_cyc[i]++;
                if (shcp_w[i] && !p_shcp[i]) begin
                    rises[i]++;
                    sr[i] = {sr[i][6:0], ds_w[i]};
                    if (ds_w[i] != p_ds[i]) viol[i]++;
                end
                if (stcp_w[i] && !p_stcp[i]) begin
                    latches[i]++;
                    q_prev[i] = q[i];
                    q[i] = sr[i];
                    st_w[i] = 0;
                end
                if (stcp_w[i]) st_w[i]++;
                if (!stcp_w[i] && p_stcp[i]) last_w[i] = st_w[i];
                if (stcp_w[i] && shcp_w[i]) viol[i]++;
            end
            p_shcp[i] = shcp_w[i];
            p_stcp[i] = stcp_w[i];
            p_ds[i]   = ds_w[i];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input int i);
        @(posedge clk); #2 mon_clr[i] = 1'b1;
        @(posedge clk); #2 mon_clr[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [7:0] b);
        @(posedge clk); #2 data_s[i] = b; wr_s[i] = 1'b1;
        @(posedge clk); #2 wr_s[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget, input string name);
        int n;
        n = 0;
        while (busy_w[i] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_w[i]) check({name, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_xfer(input int i, input string name, input logic [7:0] exp_q,
                              input int exp_busy, input int exp_rises, input int exp_latch,
                              input int exp_w);
        check({name, "_q"}, q[i], exp_q);
        check({name, "_busy_cycles"}, busy_cyc[i], exp_busy);
        check({name, "_rises"}, rises[i], exp_rises);
        check({name, "_latches"}, latches[i], exp_latch);
        check({name, "_stcp_width"}, last_w[i], exp_w);
        check({name, "_violations"}, viol[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) data_s[i] = 8'h00;
        vecs[0] = '{8'hA5, 8'hA5, 162};
        vecs[1] = '{8'h3C, 8'h3C, 162};
        vecs[2] = '{8'h00, 8'h00, 162};
        vecs[3] = '{8'hFF, 8'hFF, 162};
        vecs[4] = '{8'h81, 8'h81, 162};

        // Reset and idle
        #3 rst_n = 1'b0;
        #1;
        check("reset_outputs", {busy_w[0], ds_w[0], shcp_w[0], stcp_w[0]}, 0);
        mon_clr = 3'b111;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1; mon_clr = 3'b000;
        repeat (500) @(posedge clk);
        #2;
        check("idle_rises", rises[0], 0);
        check("idle_latches", latches[0], 0);
        check("idle_busy", busy_cyc[0], 0);
        check("idle_outputs", {busy_w[0], ds_w[0], shcp_w[0], stcp_w[0]}, 0);

        // Table-driven single transfers, MSB first, DIV=9
        for (int v = 0; v < 5; v++) begin
            clear_mon(0);
            send(0, vecs[v].data);
            wait_idle(0, 400, "vec");
            check($sformatf("vec%0d_bits", v), sr[0], vecs[v].data);
            check_xfer(0, $sformatf("vec%0d", v), vecs[v].exp_q, vecs[v].exp_busy, 8, 1, 9);
            $display("vec %0d: byte 0x%0h -> model 0x%0h busy %0d", v, vecs[v].data, q[0], busy_cyc[0]);
        end

        // wr_en held for three cycles while idle
        clear_mon(0);
        @(posedge clk); #2 data_s[0] = 8'h5A; wr_s[0] = 1'b1;
        @(posedge clk); #2 data_s[0] = 8'h66;
        @(posedge clk);
        @(posedge clk); #2 wr_s[0] = 1'b0;
        wait_idle(0, 800, "held");
`ifdef HC595_PENDING_EN
        check_xfer(0, "held", 8'h66, 324, 16, 2, 9);
`else
        check_xfer(0, "held", 8'h5A, 162, 8, 1, 9);
`endif
        $display("held wr_en: model 0x%0h rises %0d", q[0], rises[0]);

        // Second write 20 cycles into a transfer
        clear_mon(0);
        send(0, 8'h3C);
        repeat (19) @(posedge clk);
        send(0, 8'hFF);
        wait_idle(0, 800, "busywr");
`ifdef HC595_PENDING_EN
        check_xfer(0, "busywr", 8'hFF, 324, 16, 2, 9);
        check("busywr_first_latch", q_prev[0], 8'h3C);
`else
        check_xfer(0, "busywr", 8'h3C, 162, 8, 1, 9);
`endif
        $display("write while busy: model 0x%0h latches %0d", q[0], latches[0]);
        clear_mon(0);
        send(0, 8'h81);
        wait_idle(0, 400, "after");
        check_xfer(0, "after", 8'h81, 162, 8, 1, 9);
        $display("after idle: model 0x%0h", q[0]);

        // Reset after 4th shift edge aborts without a latch
        clear_mon(0);
        send(0, 8'h0F);
        for (int n = 0; n < 200 && rises[0] < 4; n++) begin
            @(negedge clk); #1;
        end
        check("abort_reach_rise4", rises[0], 4);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {busy_w[0], ds_w[0], shcp_w[0], stcp_w[0]}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #2;
        check("abort_latches", latches[0], 0);
        check("abort_model_kept", q[0], 8'h81);
        check("abort_busy", busy_w[0], 0);
        $display("abort: model 0x%0h latches %0d", q[0], latches[0]);

        // LSB first: 0x01 -> first sampled bit 1, Q7=1
        clear_mon(1);
        send(1, 8'h01);
        wait_idle(1, 400, "lsb");
        check("lsb_bits", sr[1], 8'h80);
        check_xfer(1, "lsb", 8'h80, 162, 8, 1, 9);
        $display("lsb first 0x01: model 0x%0h", q[1]);

        // Divider clamped to 1
        clear_mon(2);
        send(2, 8'hC3);
        wait_idle(2, 100, "fast");
        check_xfer(2, "fast", 8'hC3, 18, 8, 1, 1);
        $display("fast 0xC3: model 0x%0h busy %0d", q[2], busy_cyc[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
